piso_tx_scheduler: RTL

- Shares one parallel-in/serial-out shifter between two word requesters and sequences it: arbitrates, loads, shifts MSB-first, enforces an inter-word gap.
- Sits between word-producing blocks and a single serial line.
- Replaces manual load pulsing with a valid/ready handshake per requester plus framing outputs.

---
 rtl/piso_tx_scheduler_pkg.sv | 27 ++
 rtl/piso_tx_scheduler_shift_core.sv | 41 ++++
 rtl/piso_tx_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/piso_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx_scheduler_pkg
//  Description : Shared constants and helpers for the PISO transmit
//                scheduler: FSM state encoding and a counter-width function.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_tx_scheduler_pkg;

  // Scheduler state encoding
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
  localparam logic [1:0] c_ST_GAP   = 2'd2;

  // Bits needed to hold values 0..value-1; never returns less than 1 so
  // that counters stay legal vectors even for degenerate sizes.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : piso_tx_scheduler_pkg
`default_nettype wire

// File: rtl/piso_tx_scheduler_shift_core.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_core
//  Description : Parallel-in / serial-out shift register, MSB first.
//                Load has priority over shift; shifting fills with zeros,
//                so the register drains to all-zero after WIDTH shifts.
//  Ports       : Clk         - rising-edge clock
//                Reset       - synchronous active-high clear
//                load        - capture Parallel_In
//                shift_en    - shift left by one, zero fill
//                Parallel_In - word to load
//                Serial_Out  - current MSB (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_core #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] Parallel_In,
  output logic             Serial_Out
);

  logic [WIDTH-1:0] r_shreg;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_shreg <= '0;
    end else if (load) begin
      r_shreg <= Parallel_In;
    end else if (shift_en) begin
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign Serial_Out = r_shreg[WIDTH-1];

endmodule : piso_shift_core
`default_nettype wire

// File: rtl/piso_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx_scheduler
//  Description : Arbitrates two word requesters (round robin) onto a single
//                shared PISO shifter, shifts words MSB first and inserts
//                IDLE_GAP idle cycles after every word.
//  Ports       : Clk, Reset              - clock, synchronous active-high reset
//                ReqN_Valid/Data/Ready   - per-requester handshake (N = 0,1)
//                Serial_Out/Serial_Valid - serial bit and its qualifier
//                Frame_Start             - first bit of a word
//                Grant_Id                - source of the word being shifted
//                Busy                    - scheduler not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_tx_scheduler
  import piso_tx_scheduler_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int IDLE_GAP = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req0_Valid,
  input  logic [WIDTH-1:0] Req0_Data,
  output logic             Req0_Ready,
  input  logic             Req1_Valid,
  input  logic [WIDTH-1:0] Req1_Data,
  output logic             Req1_Ready,
  output logic             Serial_Out,
  output logic             Serial_Valid,
  output logic             Frame_Start,
  output logic             Grant_Id,
  output logic             Busy
);

  localparam int CW       = clog2(WIDTH);
  localparam int GW       = clog2(IDLE_GAP + 1);
  localparam int GAP_LOAD = (IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0;

  localparam logic [CW-1:0] c_BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] c_GAP_LOAD = GW'(GAP_LOAD);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_ptr;          // 0 favours requester 0
  logic             r_grant_id;
  logic             r_serial_valid;
  logic             r_frame_start;
  logic             r_busy;

  logic             w_grant;
  logic             w_idle;
  logic             w_xfer;
  logic             w_shift;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] w_data_sel;

  // --------------------------------------------------------------------------
  // Arbiter: a lone valid requester always wins; on contention the pointer
  // decides.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant = r_ptr;
    if (Req0_Valid && !Req1_Valid) begin
      w_grant = 1'b0;
    end else if (!Req0_Valid && Req1_Valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_idle     = (r_state == c_ST_IDLE);
  assign w_shift    = (r_state == c_ST_SHIFT);
  assign Req0_Ready = w_idle && !w_grant && Req0_Valid;
  assign Req1_Ready = w_idle &&  w_grant && Req1_Valid;
  assign w_xfer     = Req0_Ready || Req1_Ready;
  assign w_data_sel = w_grant ? Req1_Data : Req0_Data;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_xfer) begin
          w_next_state = c_ST_SHIFT;
        end
      end
      c_ST_SHIFT: begin
        if (r_bit_cnt == '0) begin
          w_next_state = (IDLE_GAP > 0) ? c_ST_GAP : c_ST_IDLE;
        end
      end
      c_ST_GAP: begin
        if (r_gap_cnt == '0) begin
          w_next_state = c_ST_IDLE;
        end
      end
      default: w_next_state = c_ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counters, arbitration pointer and registered outputs. The framing
  // outputs are registered from the next state so they line up with the
  // shift register contents in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= c_ST_IDLE;
      r_bit_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_ptr          <= 1'b0;
      r_grant_id     <= 1'b0;
      r_serial_valid <= 1'b0;
      r_frame_start  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_serial_valid <= (w_next_state == c_ST_SHIFT);
      r_frame_start  <= w_xfer;
      r_busy         <= (w_next_state != c_ST_IDLE);

      if (w_xfer) begin
        r_bit_cnt  <= c_BIT_LAST;
        r_grant_id <= w_grant;
        r_ptr      <= ~w_grant;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end

      // Gap counter is preloaded on the last bit so GAP lasts IDLE_GAP cycles
      if (w_shift && (r_bit_cnt == '0)) begin
        r_gap_cnt <= c_GAP_LOAD;
      end else if ((r_state == c_ST_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shared shifter. Its zero fill guarantees Serial_Out is 0 outside SHIFT.
  // --------------------------------------------------------------------------
  piso_shift_core #(
    .WIDTH (WIDTH)
  ) u_shift_core (
    .Clk         (Clk),
    .Reset       (Reset),
    .load        (w_xfer),
    .shift_en    (w_shift),
    .Parallel_In (w_data_sel),
    .Serial_Out  (Serial_Out)
  );

  assign Serial_Valid = r_serial_valid;
  assign Frame_Start  = r_frame_start;
  assign Grant_Id     = r_grant_id;
  assign Busy         = r_busy;

endmodule : piso_tx_scheduler
`default_nettype wire
